// File: rtl/stage_sequencer_pkg.sv
// Shared state encodings and sizing helpers for the fetch/decode/exec/mem/wb sequencer.
// No logic: types and constants only.
package stage_sequencer_pkg;

    localparam int STATE_W  = 4;
    localparam int RETIRE_W = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 4'd0,
        FETCH_REQ  = 4'd1,
        FETCH_WAIT = 4'd2,
        DECODE     = 4'd3,
        EXEC       = 4'd4,
        MEM_REQ    = 4'd5,
        MEM_WAIT   = 4'd6,
        WB         = 4'd7,
        HALT       = 4'd8
    } state_e;

    // Timer width able to hold n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Sequencer bus bundle: IFU and LSU handshakes, decode-class inputs, status outputs.
// master = sequencer side, slave = environment side.
interface stage_sequencer_if;
    import stage_sequencer_pkg::*;

    logic                ifu_req_valid;
    logic                ifu_req_ready;
    logic                ifu_rsp_valid;
    logic                ifu_rsp_ready;
    logic                inst_latch_en;
    logic                is_load;
    logic                is_store;
    logic                is_ebreak;
    logic                is_illegal;
    logic                has_rd;
    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic                lsu_rsp_valid;
    logic                lsu_rsp_ready;
    logic                rf_wen;
    logic                pc_wen;
    logic                halt;
    logic                illegal;
    logic                bus_err;
    logic [STATE_W-1:0]  state_o;
    logic [RETIRE_W-1:0] retire_cnt;

    modport master (
        output ifu_req_valid, ifu_rsp_ready, inst_latch_en,
        output lsu_req_valid, lsu_rsp_ready,
        output rf_wen, pc_wen, halt, illegal, bus_err, state_o, retire_cnt,
        input  ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid,
        input  is_load, is_store, is_ebreak, is_illegal, has_rd
    );

    modport slave (
        input  ifu_req_valid, ifu_rsp_ready, inst_latch_en,
        input  lsu_req_valid, lsu_rsp_ready,
        input  rf_wen, pc_wen, halt, illegal, bus_err, state_o, retire_cnt,
        output ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid,
        output is_load, is_store, is_ebreak, is_illegal, has_rd
    );

endinterface

// File: rtl/req_rsp_port.sv
// Request/response handshake qualifiers plus response-wait timeout for one port.
// Latency: combinational qualifiers; timer registered. Backpressure: valid held by the
// caller's REQ state until ready, response only accepted in the WAIT state.
module req_rsp_port
    import stage_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic req_phase,
    input  logic wait_phase,
    input  logic req_ready,
    input  logic rsp_valid,
    output logic req_valid,
    output logic rsp_ready,
    output logic accepted,
    output logic rsp_done,
    output logic timed_out
);

    localparam int            TW    = cnt_width(TIMEOUT_CYC);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] timer_q;

    assign req_valid = req_phase;
    assign rsp_ready = wait_phase;
    assign accepted  = req_phase & req_ready;
    assign rsp_done  = wait_phase & rsp_valid;
    // A response on the limit cycle takes precedence over the timeout.
    assign timed_out = wait_phase & ~rsp_valid & (timer_q == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (accepted) begin
            timer_q <= '0;
        end else if (wait_phase && !rsp_valid && timer_q != LIMIT) begin
            timer_q <= timer_q + TW'(1);
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: boot wait, fetch, decode, exec, mem, writeback, halt.
// Latency: one state per cycle, handshake states stall on ready/valid with a bounded timeout.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int BOOT_WAIT   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    stage_sequencer_if.master   bus
);

    state_e              state_q, state_d;
    logic [31:0]         boot_cnt_q;
    logic [RETIRE_W-1:0] retire_q;
    logic                illegal_q, bus_err_q;
    logic                boot_done, set_illegal, set_bus_err, retire_inc;
    logic                ifu_accept, ifu_done, ifu_to;
    logic                lsu_accept, lsu_done, lsu_to;

    assign boot_done = (BOOT_WAIT == 0) || (boot_cnt_q == 32'(BOOT_WAIT - 1));

    req_rsp_port #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ifu_port (
        .clk        (clk),
        .rst        (rst),
        .req_phase  (state_q == FETCH_REQ),
        .wait_phase (state_q == FETCH_WAIT),
        .req_ready  (bus.ifu_req_ready),
        .rsp_valid  (bus.ifu_rsp_valid),
        .req_valid  (bus.ifu_req_valid),
        .rsp_ready  (bus.ifu_rsp_ready),
        .accepted   (ifu_accept),
        .rsp_done   (ifu_done),
        .timed_out  (ifu_to)
    );

    req_rsp_port #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_lsu_port (
        .clk        (clk),
        .rst        (rst),
        .req_phase  (state_q == MEM_REQ),
        .wait_phase (state_q == MEM_WAIT),
        .req_ready  (bus.lsu_req_ready),
        .rsp_valid  (bus.lsu_rsp_valid),
        .req_valid  (bus.lsu_req_valid),
        .rsp_ready  (bus.lsu_rsp_ready),
        .accepted   (lsu_accept),
        .rsp_done   (lsu_done),
        .timed_out  (lsu_to)
    );

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        retire_inc  = 1'b0;
        case (state_q)
            IDLE:       if (boot_done) state_d = FETCH_REQ;
            FETCH_REQ:  if (ifu_accept) state_d = FETCH_WAIT;
            FETCH_WAIT: begin
                if (ifu_done) begin
                    state_d = DECODE;
                end else if (ifu_to) begin
                    state_d     = HALT;
                    set_bus_err = 1'b1;
                end
            end
            DECODE: begin
                if (bus.is_illegal) begin
                    state_d     = HALT;
                    set_illegal = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (bus.is_ebreak) begin
                    state_d    = HALT;
                    retire_inc = 1'b1;
                end else if (bus.is_load || bus.is_store) begin
                    state_d = MEM_REQ;
                end else begin
                    state_d = WB;
                end
            end
            MEM_REQ:    if (lsu_accept) state_d = MEM_WAIT;
            MEM_WAIT: begin
                if (lsu_done) begin
                    state_d = WB;
                end else if (lsu_to) begin
                    state_d     = HALT;
                    set_bus_err = 1'b1;
                end
            end
            WB: begin
                state_d    = FETCH_REQ;
                retire_inc = 1'b1;
            end
            HALT:       state_d = HALT;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            boot_cnt_q <= '0;
            retire_q   <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && !boot_done) boot_cnt_q <= boot_cnt_q + 32'd1;
            if (retire_inc)  retire_q  <= retire_q + 32'd1;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_err) bus_err_q <= 1'b1;
        end
    end

    // Latch enable coincides with the accepted response beat so decode captures live data.
    assign bus.inst_latch_en = ifu_done;
    assign bus.pc_wen        = (state_q == WB);
    assign bus.rf_wen        = (state_q == WB) & bus.has_rd & ~bus.is_store;
    assign bus.halt          = (state_q == HALT);
    assign bus.illegal       = illegal_q;
    assign bus.bus_err       = bus_err_q;
    assign bus.state_o       = state_q;
    assign bus.retire_cnt    = retire_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed, table-driven bench for stage_sequencer with hand-computed per-cycle expectations.
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stage_sequencer_if bus ();
    stage_sequencer_if bus0 ();

    stage_sequencer #(.BOOT_WAIT(2), .TIMEOUT_CYC(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    stage_sequencer #(.BOOT_WAIT(0), .TIMEOUT_CYC(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    assign bus0.ifu_req_ready = 1'b0;
    assign bus0.ifu_rsp_valid = 1'b0;
    assign bus0.lsu_req_ready = 1'b0;
    assign bus0.lsu_rsp_valid = 1'b0;
    assign bus0.is_load       = 1'b0;
    assign bus0.is_store      = 1'b0;
    assign bus0.is_ebreak     = 1'b0;
    assign bus0.is_illegal    = 1'b0;
    assign bus0.has_rd        = 1'b0;

    // Input bits
    localparam logic [8:0] I_IRDY = 9'b100000000;
    localparam logic [8:0] I_IRSP = 9'b010000000;
    localparam logic [8:0] I_LRDY = 9'b001000000;
    localparam logic [8:0] I_LRSP = 9'b000100000;
    localparam logic [8:0] I_LD   = 9'b000010000;
    localparam logic [8:0] I_ST   = 9'b000001000;
    localparam logic [8:0] I_EB   = 9'b000000100;
    localparam logic [8:0] I_ILL  = 9'b000000010;
    localparam logic [8:0] I_RD   = 9'b000000001;
    localparam logic [8:0] F      = I_IRDY | I_IRSP | I_RD;
    // Output bits
    localparam logic [9:0] O_IRV  = 10'b1000000000;
    localparam logic [9:0] O_IRR  = 10'b0100000000;
    localparam logic [9:0] O_ILE  = 10'b0010000000;
    localparam logic [9:0] O_LRV  = 10'b0001000000;
    localparam logic [9:0] O_LRR  = 10'b0000100000;
    localparam logic [9:0] O_RF   = 10'b0000010000;
    localparam logic [9:0] O_PC   = 10'b0000001000;
    localparam logic [9:0] O_HALT = 10'b0000000100;
    localparam logic [9:0] O_ILL  = 10'b0000000010;
    localparam logic [9:0] O_BUS  = 10'b0000000001;

    typedef struct {
        logic [8:0]  in;
        state_e      st;
        logic [9:0]  outs;
        int unsigned rc;
    } vec_t;

    localparam int NV = 32;
    vec_t vt [NV];

    logic [9:0] outs_v;
    assign outs_v = {bus.ifu_req_valid, bus.ifu_rsp_ready, bus.inst_latch_en,
                     bus.lsu_req_valid, bus.lsu_rsp_ready, bus.rf_wen, bus.pc_wen,
                     bus.halt, bus.illegal, bus.bus_err};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [8:0] v);
        {bus.ifu_req_ready, bus.ifu_rsp_valid, bus.lsu_req_ready, bus.lsu_rsp_valid,
         bus.is_load, bus.is_store, bus.is_ebreak, bus.is_illegal, bus.has_rd} = v;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in('0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // ALU op, load with stalls, store with has_rd, then ebreak; cycle 0 = first cycle out of reset.
        vt[0]  = '{9'h000,              IDLE,       10'h000,       0};
        vt[1]  = '{9'h000,              IDLE,       10'h000,       0};
        vt[2]  = '{F,                   FETCH_REQ,  O_IRV,         0};
        vt[3]  = '{F,                   FETCH_WAIT, O_IRR | O_ILE, 0};
        vt[4]  = '{F,                   DECODE,     10'h000,       0};
        vt[5]  = '{F,                   EXEC,       10'h000,       0};
        vt[6]  = '{F,                   WB,         O_RF | O_PC,   0};
        vt[7]  = '{F,                   FETCH_REQ,  O_IRV,         1};
        vt[8]  = '{F,                   FETCH_WAIT, O_IRR | O_ILE, 1};
        vt[9]  = '{F | I_LD,            DECODE,     10'h000,       1};
        vt[10] = '{F | I_LD,            EXEC,       10'h000,       1};
        vt[11] = '{I_LD | I_RD,         MEM_REQ,    O_LRV,         1};
        vt[12] = '{I_LD | I_RD,         MEM_REQ,    O_LRV,         1};
        vt[13] = '{I_LD | I_RD,         MEM_REQ,    O_LRV,         1};
        vt[14] = '{I_LD | I_RD | I_LRDY, MEM_REQ,   O_LRV,         1};
        vt[15] = '{I_LD | I_RD,         MEM_WAIT,   O_LRR,         1};
        vt[16] = '{I_LD | I_RD,         MEM_WAIT,   O_LRR,         1};
        vt[17] = '{I_LD | I_RD | I_LRSP, MEM_WAIT,  O_LRR,         1};
        vt[18] = '{I_LD | I_RD,         WB,         O_RF | O_PC,   1};
        vt[19] = '{F,                   FETCH_REQ,  O_IRV,         2};
        vt[20] = '{F,                   FETCH_WAIT, O_IRR | O_ILE, 2};
        vt[21] = '{F | I_ST,            DECODE,     10'h000,       2};
        vt[22] = '{F | I_ST,            EXEC,       10'h000,       2};
        vt[23] = '{I_ST | I_RD | I_LRDY, MEM_REQ,   O_LRV,         2};
        vt[24] = '{I_ST | I_RD | I_LRSP, MEM_WAIT,  O_LRR,         2};
        vt[25] = '{I_ST | I_RD,         WB,         O_PC,          2};
        vt[26] = '{F,                   FETCH_REQ,  O_IRV,         3};
        vt[27] = '{F,                   FETCH_WAIT, O_IRR | O_ILE, 3};
        vt[28] = '{F | I_EB,            DECODE,     10'h000,       3};
        vt[29] = '{F | I_EB,            EXEC,       10'h000,       3};
        vt[30] = '{F | I_EB | I_LRDY | I_LRSP, HALT, O_HALT,      4};
        vt[31] = '{9'h1FF,              HALT,       O_HALT,        4};

        do_reset();
        for (int i = 0; i < NV; i++) begin
            set_in(vt[i].in);
            #1;
            chk($sformatf("vec%0d_state", i), 32'(bus.state_o), 32'(vt[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs_v), 32'(vt[i].outs));
            chk($sformatf("vec%0d_retire", i), bus.retire_cnt, vt[i].rc);
            if (i < 3) begin
                chk($sformatf("boot0_state%0d", i), 32'(bus0.state_o),
                    (i == 0) ? 32'(IDLE) : 32'(FETCH_REQ));
                chk($sformatf("boot0_reqv%0d", i), 32'(bus0.ifu_req_valid), (i == 0) ? 32'd0 : 32'd1);
            end
            next_cycle();
        end

        // Reset out of HALT clears status; then reset in the middle of FETCH_WAIT.
        do_reset();
        #1;
        chk("rst_state", 32'(bus.state_o), 32'(IDLE));
        chk("rst_outs", 32'(outs_v), 32'd0);
        chk("rst_retire", bus.retire_cnt, 32'd0);
        set_in(I_IRDY);
        repeat (3) next_cycle();
        #1;
        chk("midrst_in_wait", 32'(bus.state_o), 32'(FETCH_WAIT));
        next_cycle();
        rst = 1'b1;
        set_in(I_IRDY | I_IRSP);
        next_cycle();
        #1;
        chk("midrst_state", 32'(bus.state_o), 32'(IDLE));
        chk("midrst_outs", 32'(outs_v), 32'd0);
        rst = 1'b0;
        chk("midrst_reqv_c0", 32'(bus.ifu_req_valid), 32'd0);
        next_cycle();
        #1;
        chk("midrst_reqv_c1", 32'(bus.ifu_req_valid), 32'd0);
        next_cycle();
        #1;
        chk("midrst_reqv_c2", 32'(bus.ifu_req_valid), 32'd1);

        // Fetch timeout, then the same with the response on the last allowed cycle.
        for (int rep = 0; rep < 2; rep++) begin
            do_reset();
            set_in(I_IRDY);
            repeat (2) next_cycle();
            #1;
            chk($sformatf("to%0d_req", rep), 32'(bus.state_o), 32'(FETCH_REQ));
            next_cycle();
            for (int k = 0; k < 8; k++) begin
                if (rep == 1 && k == 7) set_in(I_IRDY | I_IRSP);
                #1;
                chk($sformatf("to%0d_wait%0d", rep, k), 32'({bus.state_o, outs_v}),
                    32'({FETCH_WAIT, O_IRR | ((rep == 1 && k == 7) ? O_ILE : 10'h000)}));
                next_cycle();
            end
            set_in('0);
            #1;
            if (rep == 0) begin
                chk("to0_state", 32'(bus.state_o), 32'(HALT));
                chk("to0_outs", 32'(outs_v), 32'(O_HALT | O_BUS));
            end else begin
                chk("to1_state", 32'(bus.state_o), 32'(DECODE));
                chk("to1_outs", 32'(outs_v), 32'd0);
            end
        end

        // Illegal instruction halts after DECODE and stays quiet under arbitrary inputs.
        do_reset();
        set_in(F | I_ILL);
        repeat (4) next_cycle();
        #1;
        chk("ill_decode", 32'(bus.state_o), 32'(DECODE));
        next_cycle();
        #1;
        chk("ill_state", 32'(bus.state_o), 32'(HALT));
        chk("ill_outs", 32'(outs_v), 32'(O_HALT | O_ILL));
        chk("ill_retire", bus.retire_cnt, 32'd0);
        for (int c = 0; c < 100; c++) begin
            next_cycle();
            set_in(9'($urandom));
            #1;
            chk($sformatf("ill_hold%0d", c), 32'({bus.state_o, outs_v}),
                32'({HALT, O_HALT | O_ILL}));
        end
        chk("ill_retire_end", bus.retire_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
